// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit LFSR pattern generator / checker family.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 16;

  // x^16 + x^12 + x^3 + x + 1
  localparam logic [LFSR_W-1:0] LFSR_POLY_DEFAULT = 16'h100B;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  // Tap 0 closes the recurrence and is always present.
  function automatic logic [LFSR_W-1:0] lfsr_taps_eff(input logic [LFSR_W-1:0] taps);
    return taps | {{(LFSR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Next-bit predictor: XOR-reduce of the 16-bit history masked by the effective taps.
module lfsr_predict
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] hist,
  input  logic [LFSR_W-1:0] taps,
  output logic              pred
);

  assign pred = ^(hist & lfsr_taps_eff(taps));

endmodule

// File: rtl/lfsr_checker.sv
// Serial LFSR stream checker: hunts, syncs to the stream, then counts bit errors while locked.
// Optional bit_count output (valid beats seen while locked) is enabled by LFSR_CHK_BITCNT_EN.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 32,
  parameter int unsigned LOSS_COUNT = 8,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] tap_control,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              clear_count,
  output logic              locked,
  output logic              error_pulse,
  output logic [ERR_W-1:0]  error_count
`ifdef LFSR_CHK_BITCNT_EN
  ,
  output logic [31:0]       bit_count
`endif
);

  localparam logic [7:0] LockCnt = 8'(LOCK_COUNT);
  localparam logic [7:0] LossCnt = 8'(LOSS_COUNT);

  lfsr_state_e       state_q, state_d;
  logic [LFSR_W-1:0] hist_q, hist_d;
  logic [4:0]        fill_q, fill_d;
  logic [7:0]        match_q, match_d;
  logic [7:0]        miss_q, miss_d;
  logic              locked_q, locked_d;
  logic              pulse_q, pulse_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              err_hit;
  logic              pred;

  lfsr_predict u_predict (
    .hist (hist_q),
    .taps (tap_control),
    .pred (pred)
  );

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    pulse_d = 1'b0;
    err_hit = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          hist_d = {in_bit, hist_q[LFSR_W-1:1]};
          if (fill_q == 5'd15) begin
            fill_d = '0;
            if (hist_d != '0) begin
              state_d = SYNC;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        SYNC: begin
          match_d = (in_bit == pred) ? match_q + 8'd1 : '0;
          hist_d  = {in_bit, hist_q[LFSR_W-1:1]};
          if (hist_d == '0) begin
            state_d = HUNT;
            fill_d  = '0;
            match_d = '0;
          end else if (match_d == LockCnt) begin
            state_d = LOCKED;
            miss_d  = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a corrupted bit never enters the history.
          hist_d = {pred, hist_q[LFSR_W-1:1]};
          if (in_bit != pred) begin
            pulse_d = 1'b1;
            err_hit = 1'b1;
            miss_d  = miss_q + 8'd1;
            if (miss_d == LossCnt) begin
              state_d = HUNT;
              hist_d  = '0;
              fill_d  = '0;
              match_d = '0;
              miss_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d = HUNT;
          hist_d  = '0;
          fill_d  = '0;
          match_d = '0;
          miss_d  = '0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
    // Clear takes effect before a same-cycle error is counted.
    err_d = clear_count ? '0 : err_q;
    if (err_hit && (err_d != {ERR_W{1'b1}})) begin
      err_d = err_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      hist_q   <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
    end
  end

  assign locked      = locked_q;
  assign error_pulse = pulse_q;
  assign error_count = err_q;

`ifdef LFSR_CHK_BITCNT_EN
  logic [31:0] bits_q, bits_d;

  always_comb begin
    bits_d = clear_count ? '0 : bits_q;
    if (in_valid && (state_q == LOCKED)) begin
      bits_d = bits_d + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

  assign bit_count = bits_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised self-checking bench for lfsr_checker against a queue-based reference model.
module tb_lfsr_checker;

  localparam int LOCK = 32;
  localparam int LOSS = 8;

  logic        clk;
  logic        reset;
  logic [15:0] tap_control;
  logic        in_valid;
  logic        in_bit;
  logic        clear_count;
  logic        locked, locked4;
  logic        error_pulse, error_pulse4;
  logic [15:0] error_count;
  logic [3:0]  error_count4;
`ifdef LFSR_CHK_BITCNT_EN
  logic [31:0] bit_count, bit_count4;
`endif

  lfsr_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .tap_control (tap_control),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .clear_count (clear_count),
    .locked      (locked),
    .error_pulse (error_pulse),
    .error_count (error_count)
`ifdef LFSR_CHK_BITCNT_EN
    ,
    .bit_count   (bit_count)
`endif
  );

  lfsr_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_W(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .tap_control (tap_control),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .clear_count (clear_count),
    .locked      (locked4),
    .error_pulse (error_pulse4),
    .error_count (error_count4)
`ifdef LFSR_CHK_BITCNT_EN
    ,
    .bit_count   (bit_count4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stream source: first 16 bits are the seed (bit 0 first), then the recurrence.
  logic [15:0] seed_r;
  logic [15:0] gw;
  int          gen_pos;

  function automatic void gen_restart(input logic [15:0] s);
    seed_r  = s;
    gw      = s;
    gen_pos = 0;
  endfunction

  function automatic bit gen_bit();
    bit b;
    if (gen_pos < 16) begin
      b = seed_r[gen_pos];
    end else begin
      b  = ^(gw & (tap_control | 16'h0001));
      gw = {b, gw[15:1]};
    end
    gen_pos++;
    return b;
  endfunction

  // Reference model: 0 hunt, 1 sync, 2 locked; mh[k] = k-th oldest of the last 16 bits.
  int          m_state, m_fill, m_match, m_miss, m_err;
  bit          m_pulse;
  int unsigned m_bits;
  bit          mh[$];

  function automatic void model_reset();
    m_state = 0; m_fill = 0; m_match = 0; m_miss = 0; m_err = 0;
    m_pulse = 0; m_bits = 0;
    mh.delete();
    for (int k = 0; k < 16; k++) mh.push_back(1'b0);
  endfunction

  function automatic void push_bit(input bit x);
    void'(mh.pop_front());
    mh.push_back(x);
  endfunction

  function automatic int ones();
    int n = 0;
    foreach (mh[k]) n += int'(mh[k]);
    return n;
  endfunction

  function automatic void model_step(input bit v, input bit b, input bit clr);
    bit pred = 1'b0;
    m_pulse = 1'b0;
    if (clr) begin
      m_err  = 0;
      m_bits = 0;
    end
    if (!v) return;
    for (int k = 0; k < 16; k++) pred ^= mh[k] & ((k == 0) ? 1'b1 : tap_control[k]);
    if (m_state == 0) begin
      push_bit(b);
      m_fill++;
      if (m_fill == 16) begin
        m_fill = 0;
        if (ones() != 0) begin m_state = 1; m_match = 0; end
      end
    end else if (m_state == 1) begin
      m_match = (b == pred) ? m_match + 1 : 0;
      push_bit(b);
      if (ones() == 0) begin
        m_state = 0; m_fill = 0; m_match = 0;
      end else if (m_match == LOCK) begin
        m_state = 2; m_miss = 0;
      end
    end else begin
      m_bits++;
      push_bit(pred);
      if (b != pred) begin
        m_pulse = 1'b1;
        m_err++;
        m_miss++;
        if (m_miss == LOSS) begin
          m_state = 0; m_fill = 0; m_match = 0; m_miss = 0;
          for (int k = 0; k < 16; k++) mh[k] = 1'b0;
        end
      end else begin
        m_miss = 0;
      end
    end
  endfunction

  task automatic compare_all();
    check("locked", 32'(locked), 32'(m_state == 2));
    check("pulse", 32'(error_pulse), 32'(m_pulse));
    check("err16", 32'(error_count), (m_err > 65535) ? 32'd65535 : 32'(m_err));
    check("locked4", 32'(locked4), 32'(m_state == 2));
    check("err4", 32'(error_count4), (m_err > 15) ? 32'd15 : 32'(m_err));
`ifdef LFSR_CHK_BITCNT_EN
    check("bitcnt", bit_count, m_bits);
`endif
  endtask

  task automatic beat(input bit v, input bit b, input bit clr);
    @(negedge clk);
    in_valid    = v;
    in_bit      = b;
    clear_count = clr;
    @(posedge clk);
    model_step(v, b, clr);
    #1;
    compare_all();
  endtask

  task automatic clean_beat();
    beat(1'b1, gen_bit(), 1'b0);
  endtask

  task automatic bad_beat();
    beat(1'b1, ~gen_bit(), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; clear_count = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; tap_control = 16'h100B;
    in_valid = 1'b0; in_bit = 1'b0; clear_count = 1'b0;
    model_reset();
    do_reset();

    // Clean lock from seed 1: lock visible right after beat 48.
    gen_restart(16'h0001);
    for (int i = 1; i <= 48; i++) begin
      clean_beat();
      check("lock_lat", 32'(locked), 32'(i == 48));
    end
    check("clean_err", 32'(error_count), 32'd0);

    // Single error.
    for (int i = 0; i < 10; i++) clean_beat();
    bad_beat();
    check("single_pulse", 32'(error_pulse), 32'd1);
    for (int i = 0; i < 20; i++) clean_beat();
    check("single_cnt", 32'(error_count), 32'd1);
    check("single_lock", 32'(locked), 32'd1);

    // Loss of lock on the 8th consecutive error, then re-lock.
    beat(1'b1, gen_bit(), 1'b1);
    for (int i = 1; i <= LOSS; i++) begin
      bad_beat();
      check("loss_lock", 32'(locked), 32'(i < LOSS));
    end
    check("loss_cnt", 32'(error_count), 32'(LOSS));
    for (int i = 1; i <= 48; i++) begin
      clean_beat();
      check("relock", 32'(locked), 32'(i == 48));
    end

    // Gaps: same valid-beat latency with in_valid toggling.
    do_reset();
    gen_restart(16'hACE1);
    for (int i = 1; i <= 48; i++) begin
      clean_beat();
      check("gap_lat", 32'(locked), 32'(i == 48));
      beat(1'b0, 1'($urandom), 1'b0);
    end

    // Five errors, then clear together with an error.
    for (int i = 0; i < 5; i++) begin bad_beat(); clean_beat(); end
    check("five", 32'(error_count), 32'd5);
    beat(1'b1, ~gen_bit(), 1'b1);
    check("clr_err", 32'(error_count), 32'd1);

    // Saturation of the 4-bit counter while lock is held.
    for (int i = 0; i < 20; i++) begin bad_beat(); clean_beat(); end
    check("sat4", 32'(error_count4), 32'd15);
    check("sat16", 32'(error_count), 32'd21);
    check("sat_lock", 32'(locked4), 32'd1);

    // Randomised traffic: gaps, sparse errors, occasional clears.
    for (int i = 0; i < 600; i++) begin
      bit v, clr, b;
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      if (v) begin
        b = gen_bit();
        if ($urandom_range(0, 24) == 0) b = ~b;
      end else begin
        b = 1'($urandom);
      end
      beat(v, b, clr);
    end

    // All-zero stream never leaves hunt.
    do_reset();
    for (int i = 0; i < 100; i++) beat(1'b1, 1'b0, 1'b0);
    check("zero_lock", 32'(locked), 32'd0);
    check("zero_err", 32'(error_count), 32'd0);

    // Asynchronous reset mid-run.
    gen_restart(16'h0001);
    for (int i = 0; i < 48; i++) clean_beat();
    for (int i = 0; i < 3; i++) begin bad_beat(); clean_beat(); end
    check("pre_rst_err", 32'(error_count), 32'd3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_lock", 32'(locked), 32'd0);
    check("async_err", 32'(error_count), 32'd0);
    check("async_err4", 32'(error_count4), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    beat(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
